// File: rtl/tff_pkg.sv
// Shared definitions for the toggle flip-flop counter family.
// Holds the SATURATE mode encodings and the helper functions used for the
// load clamp and the MAX_COUNT legality check.
// No ports: this is a package.
package tff_pkg;

    // Behaviour when an enabled count reaches a bound
    localparam int unsigned WRAP_MODE = 0;
    localparam int unsigned SAT_MODE  = 1;

    // Limits a load value to the highest legal count. Both operands are
    // carried at 32 bits, the widest counter allowed, so no bits are lost
    // before the comparison.
    function automatic logic [31:0] clampToMax(input logic [31:0] value,
                                               input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

    // True when maxCount is a usable modulus for a counter of the given
    // width: non-zero and representable in width bits.
    function automatic bit maxFitsWidth(input longint unsigned maxCount,
                                        input int unsigned     width);
        longint unsigned fullScale;
        fullScale = (64'd1 << width) - 64'd1;
        return (maxCount != 0) && (maxCount <= fullScale);
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit toggle flip-flop cell with synchronous override.
// Ports:
//   Clock    - rising-edge clock
//   Clear    - synchronous active-low clear (Q=0, Qbar=1)
//   T        - toggle request
//   ForceEn  - load ForceVal instead of toggling (takes priority over T)
//   ForceVal - value loaded when ForceEn is high
//   Q, Qbar  - registered state and its registered complement
module tff_cell (
    input  logic Clock,
    input  logic Clear,
    input  logic T,
    input  logic ForceEn,
    input  logic ForceVal,
    output logic Q,
    output logic Qbar
);

    logic q_q;
    logic q_d;
    logic qbar_q;

    // Next-state selection: a forced value beats a toggle request
    always_comb begin
        q_d = q_q;
        if (ForceEn) begin
            q_d = ForceVal;
        end else if (T) begin
            q_d = ~q_q;
        end
    end

    // Qbar has its own flop so both outputs come straight from registers
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            q_q    <= 1'b0;
            qbar_q <= 1'b1;
        end else begin
            q_q    <= q_d;
            qbar_q <= ~q_d;
        end
    end

    assign Q    = q_q;
    assign Qbar = qbar_q;

endmodule

// File: rtl/tff_updown_counter.sv
// Parametrised up/down counter built from per-bit toggle cells.
// Parameters: WIDTH (2..32), MAX_COUNT (1..2**WIDTH-1), SATURATE (WRAP_MODE/SAT_MODE).
// Ports:
//   Clock - rising-edge clock
//   Clear - synchronous active-low reset
//   En    - count enable
//   Up    - direction, 1 = increment, 0 = decrement
//   Load  - synchronous parallel load of D (clamped to MAX_COUNT)
//   D     - load value
//   Q     - registered count, Qbar its registered complement
//   TC    - terminal count for the current direction (combinational)
//   Wrap  - registered one-cycle pulse after a wrapping edge
module tff_updown_counter
    import tff_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter logic [31:0] MAX_COUNT = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int unsigned SATURATE  = WRAP_MODE
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             TC,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];

    // Reject illegal configurations while elaborating
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("tff_updown_counter: WIDTH must be in 2..32");
    end
    if (!maxFitsWidth(64'(MAX_COUNT), WIDTH)) begin : g_bad_max
        $error("tff_updown_counter: MAX_COUNT must be in 1..2**WIDTH-1");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] countBar_q;
    logic [WIDTH-1:0] toggleChain;
    logic [WIDTH-1:0] forceVal;
    logic [WIDTH-1:0] loadVal;
    logic             atTop;
    logic             atBottom;
    logic             atBound;
    logic             forceEn;
    logic             wrap_d;
    logic             wrap_q;

    // Bound detection and the override path. Any enabled step taken at a
    // bound is forced rather than toggled, so a modulus that is not all ones
    // still lands exactly on 0 or MAX_COUNT. In saturate mode the force
    // value is the current count, which turns the step into a hold.
    always_comb begin
        atTop    = (count_q == MAX_VAL);
        atBottom = (count_q == '0);
        atBound  = Up ? atTop : atBottom;
        loadVal  = WIDTH'(clampToMax(32'(D), MAX_COUNT));
        forceEn  = Load | (En & atBound);
        if (Load) begin
            forceVal = loadVal;
        end else if (SATURATE == SAT_MODE) begin
            forceVal = count_q;
        end else if (Up) begin
            forceVal = '0;
        end else begin
            forceVal = MAX_VAL;
        end
        wrap_d = ~Load & En & atBound & (SATURATE == WRAP_MODE);
    end

    // Toggle chain: bit i flips when every lower bit is 1 counting up, or
    // every lower bit is 0 counting down. Bit 0 flips on every step.
    assign toggleChain[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign toggleChain[i] = Up ? (&count_q[i-1:0]) : ~(|count_q[i-1:0]);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cells
        tff_cell u_cell (
            .Clock   (Clock),
            .Clear   (Clear),
            .T       (En & toggleChain[i]),
            .ForceEn (forceEn),
            .ForceVal(forceVal[i]),
            .Q       (count_q[i]),
            .Qbar    (countBar_q[i])
        );
    end

    // Wrap is a single-cycle marker of the edge that crossed a bound
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign Q    = count_q;
    assign Qbar = countBar_q;
    assign TC   = atBound;
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Bench for tff_updown_counter. Four instances run side by side on shared
// controls: A (WIDTH=4, full range), B (WIDTH=4, MAX=9, wrap),
// C (WIDTH=4, MAX=9, saturate) and D (WIDTH=8, full range). An arithmetic
// model predicts every instance each cycle; predictions go into a queue and
// are popped after the edge.
module tb_tff_updown_counter;

    typedef struct {
        int         dut;
        logic [7:0] q;
        logic [7:0] qb;
        logic       wrap;
        logic       tc;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Clear = 1'b0;
    logic       En    = 1'b0;
    logic       Up    = 1'b0;
    logic       Load  = 1'b0;
    logic [7:0] D     = 8'h00;

    logic [3:0] qA, qbA, qB, qbB, qC, qbC;
    logic [7:0] qD, qbD;
    logic       tcA, tcB, tcC, tcD, wrapA, wrapB, wrapC, wrapD;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   modelQ[4];
    int   mx[4]    = '{15, 9, 9, 255};
    bit   sat[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    int   dmask[4] = '{15, 15, 15, 255};

    // Free-running clock
    always #5 Clock = ~Clock;

    tff_updown_counter #(.WIDTH(4)) dutA (
        .Clock(Clock), .Clear(Clear), .En(En), .Up(Up), .Load(Load), .D(D[3:0]),
        .Q(qA), .Qbar(qbA), .TC(tcA), .Wrap(wrapA));
    tff_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dutB (
        .Clock(Clock), .Clear(Clear), .En(En), .Up(Up), .Load(Load), .D(D[3:0]),
        .Q(qB), .Qbar(qbB), .TC(tcB), .Wrap(wrapB));
    tff_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) dutC (
        .Clock(Clock), .Clear(Clear), .En(En), .Up(Up), .Load(Load), .D(D[3:0]),
        .Q(qC), .Qbar(qbC), .TC(tcC), .Wrap(wrapC));
    tff_updown_counter #(.WIDTH(8)) dutD (
        .Clock(Clock), .Clear(Clear), .En(En), .Up(Up), .Load(Load), .D(D),
        .Q(qD), .Qbar(qbD), .TC(tcD), .Wrap(wrapD));

    // Reference behaviour written as plain arithmetic with explicit bounds
    function automatic void modelNext(input int m, input bit s, input int q,
                                      input logic c, input logic l, input logic e,
                                      input logic u, input int d,
                                      output int nq, output bit w);
        w  = 1'b0;
        nq = q;
        if (!c) begin
            nq = 0;
        end else if (l) begin
            nq = (d > m) ? m : d;
        end else if (e) begin
            if (u) begin
                if (q == m) begin
                    if (!s) begin nq = 0; w = 1'b1; end
                end else begin
                    nq = q + 1;
                end
            end else begin
                if (q == 0) begin
                    if (!s) begin nq = m; w = 1'b1; end
                end else begin
                    nq = q - 1;
                end
            end
        end
    endfunction

    // Reads one instance's outputs zero-extended to 8 bits
    function automatic void observe(input int idx, output logic [7:0] q,
                                    output logic [7:0] qb, output logic w,
                                    output logic tc);
        case (idx)
            0:       begin q = {4'h0, qA}; qb = {4'h0, qbA}; w = wrapA; tc = tcA; end
            1:       begin q = {4'h0, qB}; qb = {4'h0, qbB}; w = wrapB; tc = tcB; end
            2:       begin q = {4'h0, qC}; qb = {4'h0, qbC}; w = wrapC; tc = tcC; end
            default: begin q = qD;         qb = qbD;         w = wrapD; tc = tcD; end
        endcase
    endfunction

    // Drives one cycle of controls, queues predictions, waits past the edge
    task automatic applyStimulus(input logic c, input logic l, input logic e,
                                 input logic u, input logic [7:0] d);
        exp_t x;
        int   nq;
        bit   w;
        Clear = c; Load = l; En = e; Up = u; D = d;
        for (int k = 0; k < 4; k++) begin
            modelNext(mx[k], sat[k], modelQ[k], c, l, e, u, int'(d) & dmask[k], nq, w);
            modelQ[k] = nq;
            x.dut  = k;
            x.q    = 8'(nq);
            x.qb   = 8'(~nq & dmask[k]);
            x.wrap = w;
            x.tc   = u ? (nq == mx[k]) : (nq == 0);
            sb.push_back(x);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        exp_t e; logic [7:0] oq, oqb; logic ow, otc;
        for (int n = 0; n < 2; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h05);
            repeat (4) begin
                e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
                checks++;
                if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                    failures++;
                    $display("[TB] FAIL reset dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                             e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
                end
            end
        end
        checks++;
        if (qA !== 4'h0 || qbA !== 4'hF || wrapA !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_const: got q=%h qb=%h wrap=%b, want 0 F 0", qA, qbA, wrapA);
        end
    endtask

    task automatic test_count_up;
        exp_t e; logic [7:0] oq, oqb; logic ow, otc;
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
            repeat (4) begin
                e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
                checks++;
                if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                    failures++;
                    $display("[TB] FAIL count_up dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                             e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
                end
            end
            checks++;
            if (qA !== 4'((n + 1) % 16) || wrapA !== (n == 15)) begin
                failures++;
                $display("[TB] FAIL count_up_const step %0d: got q=%h wrap=%b, want q=%h wrap=%b",
                         n, qA, wrapA, 4'((n + 1) % 16), (n == 15));
            end
        end
    endtask

    task automatic test_down_wrap;
        exp_t e; logic [7:0] oq, oqb; logic ow, otc;
        logic [3:0] wantQ[3] = '{4'd9, 4'd8, 4'd7};
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (4) begin
            e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
            checks++;
            if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                failures++;
                $display("[TB] FAIL down_load dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                         e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
            end
        end
        checks++;
        if (qB !== 4'd0 || tcB !== 1'b1) begin
            failures++;
            $display("[TB] FAIL down_tc_at_zero: got q=%h tc=%b, want 0 1", qB, tcB);
        end
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            repeat (4) begin
                e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
                checks++;
                if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                    failures++;
                    $display("[TB] FAIL down_wrap dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                             e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
                end
            end
            checks++;
            if (qB !== wantQ[n] || wrapB !== (n == 0)) begin
                failures++;
                $display("[TB] FAIL down_wrap_const step %0d: got q=%h wrap=%b, want q=%h wrap=%b",
                         n, qB, wrapB, wantQ[n], (n == 0));
            end
        end
    endtask

    task automatic test_saturate;
        exp_t e; logic [7:0] oq, oqb; logic ow, otc;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h08);
        for (int n = 0; n < 4; n++) begin
            if (n > 0) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
            repeat (4) begin
                e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
                checks++;
                if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                    failures++;
                    $display("[TB] FAIL saturate dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                             e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
                end
            end
            if (n > 0) begin
                checks++;
                if (qC !== 4'd9 || wrapC !== 1'b0 || tcC !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL saturate_const step %0d: got q=%h wrap=%b tc=%b, want 9 0 1",
                             n, qC, wrapC, tcC);
                end
            end
        end
    endtask

    task automatic test_clamp_priority;
        exp_t e; logic [7:0] oq, oqb; logic ow, otc;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h0E);
        repeat (4) begin
            e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
            checks++;
            if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                failures++;
                $display("[TB] FAIL clamp dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                         e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
            end
        end
        checks++;
        if (qB !== 4'd9 || qA !== 4'hE) begin
            failures++;
            $display("[TB] FAIL clamp_const: got qB=%h qA=%h, want 9 E", qB, qA);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h0E);
        repeat (4) begin
            e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
            checks++;
            if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                failures++;
                $display("[TB] FAIL clear_over_load dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                         e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
            end
        end
        checks++;
        if (qB !== 4'd0) begin
            failures++;
            $display("[TB] FAIL clear_over_load_const: got q=%h, want 0", qB);
        end
    endtask

    task automatic test_mid_reset;
        exp_t e; logic [7:0] oq, oqb; logic ow, otc;
        for (int n = 0; n < 8; n++) begin
            applyStimulus((n == 6) ? 1'b0 : 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
            repeat (4) begin
                e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
                checks++;
                if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                    failures++;
                    $display("[TB] FAIL mid_reset dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                             e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
                end
            end
            if (n >= 5) begin
                checks++;
                if (qD !== ((n == 5) ? 8'd6 : (n == 6) ? 8'd0 : 8'd1)) begin
                    failures++;
                    $display("[TB] FAIL mid_reset_const step %0d: got q=%h", n, qD);
                end
            end
        end
    endtask

    task automatic test_hold;
        exp_t e; logic [7:0] oq, oqb; logic ow, otc;
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, n[0], 8'h00);
            repeat (4) begin
                e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
                checks++;
                if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                    failures++;
                    $display("[TB] FAIL hold dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                             e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
                end
            end
            checks++;
            if (qD !== 8'd1 || tcD !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_const step %0d: got q=%h tc=%b, want 01 0", n, qD, tcD);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e; logic [7:0] oq, oqb; logic ow, otc;
        // load 15, load+en at top, up, up, down, down, up
        logic       lds[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       ups[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] wq[7]   = '{4'hF, 4'hF, 4'h0, 4'h1, 4'h0, 4'hF, 4'h0};
        logic       ww[7]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int n = 0; n < 7; n++) begin
            applyStimulus(1'b1, lds[n], (n != 0), ups[n], 8'h0F);
            repeat (4) begin
                e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
                checks++;
                if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                    failures++;
                    $display("[TB] FAIL back_to_back dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                             e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
                end
            end
            checks++;
            if (qA !== wq[n] || wrapA !== ww[n]) begin
                failures++;
                $display("[TB] FAIL back_to_back_const step %0d: got q=%h wrap=%b, want q=%h wrap=%b",
                         n, qA, wrapA, wq[n], ww[n]);
            end
        end
    endtask

    task automatic test_random;
        exp_t e; logic [7:0] oq, oqb; logic ow, otc;
        for (int n = 0; n < 80; n++) begin
            applyStimulus(($urandom_range(0, 15) != 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)));
            repeat (4) begin
                e = sb.pop_front(); observe(e.dut, oq, oqb, ow, otc);
                checks++;
                if (oq !== e.q || oqb !== e.qb || ow !== e.wrap || otc !== e.tc) begin
                    failures++;
                    $display("[TB] FAIL random dut%0d: got q=%h qb=%h wrap=%b tc=%b, want q=%h qb=%h wrap=%b tc=%b",
                             e.dut, oq, oqb, ow, otc, e.q, e.qb, e.wrap, e.tc);
                end
            end
        end
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        #2;
        test_reset();
        test_count_up();
        test_down_wrap();
        test_saturate();
        test_clamp_priority();
        test_mid_reset();
        test_hold();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
